// File: rtl/spi_master_cfg.sv
// SPI master with per-transfer mode (CPOL/CPHA) and bit order, latched at accept.
// One word per transfer; sclk half-period is CLK_DIV clk cycles.
module spi_master_cfg #(
  parameter int unsigned DATA_W  = 12,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              newd,
  input  logic [DATA_W-1:0] din,
  input  logic [1:0]        mode,
  input  logic              lsb_first,
  input  logic              miso,
  output logic              sclk,
  output logic              cs,
  output logic              mosi,
  output logic [DATA_W-1:0] dout,
  output logic              done,
  output logic              busy
);

  localparam int unsigned EdgeW = $clog2(2 * DATA_W + 2);
  localparam int unsigned DivW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [EdgeW-1:0] LastEdge = EdgeW'(2 * DATA_W);
  localparam logic [DivW-1:0]  DivMax   = DivW'(CLK_DIV - 1);

  typedef enum logic [1:0] {StIdle, StXfer, StDone} state_e;

  state_e            state;
  logic              cpol, cpha, lsb;
  logic [DATA_W-1:0] tx, rx;
  logic [DivW-1:0]   div_cnt;
  logic [EdgeW-1:0]  edge_cnt;

  logic              tick;
  logic [EdgeW-1:0]  edge_nxt;
  logic              first_bit, tx_bit, sample;
  logic [DATA_W-1:0] din_shift, tx_shift, rx_shift;

  assign tick      = (div_cnt == DivMax);
  assign edge_nxt  = edge_cnt + 1'b1;
  assign first_bit = lsb_first ? din[0] : din[DATA_W-1];
  assign din_shift = lsb_first ? {1'b0, din[DATA_W-1:1]} : {din[DATA_W-2:0], 1'b0};
  assign tx_bit    = lsb ? tx[0] : tx[DATA_W-1];
  assign tx_shift  = lsb ? {1'b0, tx[DATA_W-1:1]} : {tx[DATA_W-2:0], 1'b0};
  assign rx_shift  = lsb ? {miso, rx[DATA_W-1:1]} : {rx[DATA_W-2:0], miso};
  // CPHA=0 samples on odd edges, CPHA=1 on even edges
  assign sample    = edge_nxt[0] ^ cpha;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= StIdle;
      cs       <= 1'b1;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
      dout     <= '0;
      cpol     <= 1'b0;
      cpha     <= 1'b0;
      lsb      <= 1'b0;
      tx       <= '0;
      rx       <= '0;
      div_cnt  <= '0;
      edge_cnt <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (newd) begin
            state    <= StXfer;
            cs       <= 1'b0;
            busy     <= 1'b1;
            cpol     <= mode[1];
            cpha     <= mode[0];
            lsb      <= lsb_first;
            sclk     <= mode[1];
            div_cnt  <= '0;
            edge_cnt <= '0;
            rx       <= '0;
            if (mode[0]) begin
              mosi <= 1'b0;
              tx   <= din;
            end else begin
              mosi <= first_bit;
              tx   <= din_shift;
            end
          end
        end
        StXfer: begin
          div_cnt <= tick ? '0 : div_cnt + 1'b1;
          if (tick) begin
            edge_cnt <= edge_nxt;
            if (edge_nxt > LastEdge) begin
              // Final half-period elapsed: close the frame
              state <= StDone;
              cs    <= 1'b1;
              busy  <= 1'b0;
              done  <= 1'b1;
              dout  <= rx;
              mosi  <= 1'b0;
              sclk  <= cpol;
            end else begin
              sclk <= ~sclk;
              if (sample) begin
                rx <= rx_shift;
              end else if (cpha || (edge_nxt != LastEdge)) begin
                mosi <= tx_bit;
                tx   <= tx_shift;
              end
            end
          end
        end
        StDone: state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end

endmodule
